// File: rtl/bus_arbiter_if.sv
// Bundle of the per-core data-bus ports and the shared downstream bus seen by bus_arbiter.
// The slave modport is the arbiter's view; master is the cores-plus-memory side.
interface bus_arbiter_if #(
  parameter int NUM_CORES = 2,
  parameter int ID_WIDTH  = 1
);
  logic [NUM_CORES*32-1:0] core_bus_address;
  logic [NUM_CORES*32-1:0] core_bus_write_data;
  logic [NUM_CORES*4-1:0]  core_bus_byte_enable;
  logic [NUM_CORES-1:0]    core_bus_write_enable;
  logic [NUM_CORES-1:0]    core_bus_read_enable;
  logic [31:0]             core_bus_read_data;
  logic [NUM_CORES-1:0]    core_bus_busy;
  logic [31:0]             mem_address;
  logic [31:0]             mem_write_data;
  logic [3:0]              mem_byte_enable;
  logic                    mem_write_enable;
  logic                    mem_read_enable;
  logic [31:0]             mem_read_data;
  logic                    mem_ready;
  logic                    grant_valid;
  logic [ID_WIDTH-1:0]     grant_id;

  modport slave (
    input  core_bus_address, core_bus_write_data, core_bus_byte_enable,
    input  core_bus_write_enable, core_bus_read_enable, mem_read_data, mem_ready,
    output core_bus_read_data, core_bus_busy, mem_address, mem_write_data,
    output mem_byte_enable, mem_write_enable, mem_read_enable, grant_valid, grant_id
  );

  modport master (
    output core_bus_address, core_bus_write_data, core_bus_byte_enable,
    output core_bus_write_enable, core_bus_read_enable, mem_read_data, mem_ready,
    input  core_bus_read_data, core_bus_busy, mem_address, mem_write_data,
    input  mem_byte_enable, mem_write_enable, mem_read_enable, grant_valid, grant_id
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter serialising NUM_CORES core data-bus ports onto one downstream bus.
// Every grant passes through IDLE, so priority rotates and enables drop between accesses.
module bus_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ID_WIDTH  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0]  req_s;
  logic [ID_WIDTH-1:0]   winner_s;
  logic                  found_s;
  logic                  in_access_s;
  logic                  gnt_req_s;
  logic [ID_WIDTH-1:0]   next_ptr_s;

  assign req_s       = bus.core_bus_write_enable | bus.core_bus_read_enable;
  assign in_access_s = (state_q == ACCESS);
  assign gnt_req_s   = req_s[grant_id_q];
  assign next_ptr_s  = (grant_id_q == ID_WIDTH'(NUM_CORES - 1)) ? {ID_WIDTH{1'b0}}
                                                                 : grant_id_q + ID_WIDTH'(1);

  // Priority scan starting at rr_ptr, wrapping modulo NUM_CORES; first requester wins.
  always_comb begin
    winner_s = {ID_WIDTH{1'b0}};
    found_s  = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      int   idx;
      logic hit;
      idx = int'(rr_ptr_q) + k;
      idx = (idx >= NUM_CORES) ? idx - NUM_CORES : idx;
      hit      = !found_s && req_s[idx];
      winner_s = hit ? ID_WIDTH'(idx) : winner_s;
      found_s  = found_s | hit;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on completion or abort.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = ACCESS;
          grant_id_d = winner_s;
        end else begin
          state_d    = IDLE;
        end
      end
      ACCESS: begin
        // A dropped request without mem_ready is an abort; it rotates priority like a completion.
        if (bus.mem_ready || !gnt_req_s) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr_s;
        end else begin
          state_d  = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= {ID_WIDTH{1'b0}};
      rr_ptr_q   <= {ID_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Downstream mux of the granted core; everything is zero outside ACCESS.
  always_comb begin
    logic wr_s;
    logic rd_s;
    wr_s = bus.core_bus_write_enable[grant_id_q];
    rd_s = bus.core_bus_read_enable[grant_id_q];
    bus.mem_address      = in_access_s ? bus.core_bus_address[int'(grant_id_q)*32 +: 32] : 32'h0;
    bus.mem_write_data   = in_access_s ? bus.core_bus_write_data[int'(grant_id_q)*32 +: 32] : 32'h0;
    bus.mem_byte_enable  = in_access_s ? bus.core_bus_byte_enable[int'(grant_id_q)*4 +: 4] : 4'h0;
    bus.mem_write_enable = in_access_s & wr_s;
    bus.mem_read_enable  = in_access_s & rd_s & ~wr_s;
  end

  // Busy holds every requester until its own completion cycle.
  always_comb begin
    bus.core_bus_busy = {NUM_CORES{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      bus.core_bus_busy[i] = req_s[i] &
                             ~(in_access_s & (int'(grant_id_q) == i) & bus.mem_ready);
    end
  end

  assign bus.core_bus_read_data = bus.mem_read_data;
  assign bus.grant_valid        = in_access_s;
  assign bus.grant_id           = grant_id_q;

endmodule
